// File: rtl/rcu_pkg.sv
// Shared rename/commit-unit definitions: datapath widths, writeback source indices
// and the request record carried through the writeback FIFOs.
package rcu_pkg;

    localparam int XLEN           = 64;
    localparam int REG_SIZE_WIDTH = 6;
    localparam int NUM_WB_SRC     = 6;

    localparam int WB_ALU1  = 0;
    localparam int WB_ALU2  = 1;
    localparam int WB_FALU1 = 2;
    localparam int WB_FALU2 = 3;
    localparam int WB_LSU   = 4;
    localparam int WB_MD    = 5;

    typedef struct packed {
        logic [REG_SIZE_WIDTH-1:0] addr;
        logic [XLEN-1:0]           data;
    } wb_req_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Small synchronous FIFO holding pending writebacks for one execution unit.
// Push into a full FIFO or pop from an empty one is ignored.
module wb_src_fifo
    import rcu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_req_t                  push_data,
    input  logic                     pop,
    output wb_req_t                  head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    wb_req_t        mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           push_ok;
    logic           pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers results from each execution unit and issues up to two
// round-robin-fair register writes per cycle on the regfile write ports.
module wb_arbiter #(
    parameter int NUM_SRC        = rcu_pkg::NUM_WB_SRC,
    parameter int DEPTH          = 2,
    parameter int REG_SIZE_WIDTH = rcu_pkg::REG_SIZE_WIDTH,
    parameter int XLEN           = rcu_pkg::XLEN
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SRC-1:0]                src_valid_i,
    input  logic [NUM_SRC*REG_SIZE_WIDTH-1:0] src_addr_i,
    input  logic [NUM_SRC*XLEN-1:0]           src_data_i,
    output logic [NUM_SRC-1:0]                src_ready_o,
    output logic                              wr_first_valid_o,
    output logic [REG_SIZE_WIDTH-1:0]         wr_first_address_o,
    output logic [XLEN-1:0]                   wr_first_data_o,
    output logic                              wr_second_valid_o,
    output logic [REG_SIZE_WIDTH-1:0]         wr_second_address_o,
    output logic [XLEN-1:0]                   wr_second_data_o
);

    import rcu_pkg::*;

    localparam int IW = $clog2(NUM_SRC);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_req_t           head [NUM_SRC];
    logic [CW-1:0]     count [NUM_SRC];
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     g0;
    logic [IW-1:0]     g1;
    logic [IW-1:0]     idx;
    logic              g0_vld;
    logic              g1_vld;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        wb_req_t req_in;
        assign req_in = '{addr: src_addr_i[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH],
                          data: src_data_i[k*XLEN +: XLEN]};
        assign src_ready_o[k] = (count[k] != CW'(DEPTH));
        // Writes to p0 are swallowed at the door; they are accepted but never queued.
        assign push[k] = src_valid_i[k] && !full[k] && (req_in.addr != '0);
        assign pop[k]  = (g0_vld && g0 == IW'(k)) || (g1_vld && g1 == IW'(k));

        wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[k]),
            .push_data (req_in),
            .pop       (pop[k]),
            .head      (head[k]),
            .empty     (empty[k]),
            .full      (full[k]),
            .count     (count[k])
        );
    end

    // Second grant skips a head that targets the same preg as the first grant;
    // that source simply waits for a later cycle.
    always_comb begin
        g0_vld = 1'b0;
        g0     = '0;
        g1_vld = 1'b0;
        g1     = '0;
        idx    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = IW'((int'(rr_ptr) + i) % NUM_SRC);
            if (!g0_vld && !empty[idx]) begin
                g0_vld = 1'b1;
                g0     = idx;
            end
        end
        for (int i = 1; i < NUM_SRC; i++) begin
            idx = IW'((int'(g0) + i) % NUM_SRC);
            if (g0_vld && !g1_vld && !empty[idx] && head[idx].addr != head[g0].addr) begin
                g1_vld = 1'b1;
                g1     = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr              <= '0;
            wr_first_valid_o    <= 1'b0;
            wr_first_address_o  <= '0;
            wr_first_data_o     <= '0;
            wr_second_valid_o   <= 1'b0;
            wr_second_address_o <= '0;
            wr_second_data_o    <= '0;
        end else begin
            wr_first_valid_o    <= g0_vld;
            wr_first_address_o  <= g0_vld ? head[g0].addr : '0;
            wr_first_data_o     <= g0_vld ? head[g0].data : '0;
            wr_second_valid_o   <= g1_vld;
            wr_second_address_o <= g1_vld ? head[g1].addr : '0;
            wr_second_data_o    <= g1_vld ? head[g1].data : '0;
            if (g1_vld)
                rr_ptr <= IW'((int'(g1) + 1) % NUM_SRC);
            else if (g0_vld)
                rr_ptr <= IW'((int'(g0) + 1) % NUM_SRC);
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: accepted writes go into per-source expected queues
// and a negedge monitor retires every regfile write against them.
module tb_wb_arbiter;

    localparam int NS = 6;
    localparam int AW = 6;
    localparam int DW = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NS-1:0]      src_valid = '0;
    logic [NS*AW-1:0]   src_addr = '0;
    logic [NS*DW-1:0]   src_data = '0;
    logic [NS-1:0]      src_ready;
    logic               f_vld, s_vld;
    logic [AW-1:0]      f_addr, s_addr;
    logic [DW-1:0]      f_data, s_data;

    int compared   = 0;
    int mismatched = 0;

    logic [AW+DW-1:0] exp_q [NS][$];

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .src_valid_i         (src_valid),
        .src_addr_i          (src_addr),
        .src_data_i          (src_data),
        .src_ready_o         (src_ready),
        .wr_first_valid_o    (f_vld),
        .wr_first_address_o  (f_addr),
        .wr_first_data_o     (f_data),
        .wr_second_valid_o   (s_vld),
        .wr_second_address_o (s_addr),
        .wr_second_data_o    (s_data)
    );

    function automatic logic [DW-1:0] tag(input int src, input int val);
        return (64'(src) << 60) | 64'(val);
    endfunction

    task automatic chk(input string name, input logic [AW+DW-1:0] got, input logic [AW+DW-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard retire: the source is encoded in the top data nibble.
    task automatic sb_retire(input string port, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int s;
        logic [AW+DW-1:0] e;
        s = int'(d[DW-1 -: 4]);
        compared++;
        if (s >= NS || exp_q[s].size() == 0) begin
            mismatched++;
            $display("FAIL %s unexpected write: got addr %0h data %0h expected none", port, a, d);
        end else begin
            e = exp_q[s].pop_front();
            if (e !== {a, d}) begin
                mismatched++;
                $display("FAIL %s order: got %0h expected %0h", port, {a, d}, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (f_vld) sb_retire("port0", f_addr, f_data);
            if (s_vld) sb_retire("port1", s_addr, s_data);
            if (f_vld && s_vld) begin
                compared++;
                if (f_addr == s_addr) begin
                    mismatched++;
                    $display("FAIL dual_same_addr: got %0h on both ports expected distinct", f_addr);
                end
            end
        end
    end

    task automatic set_src(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        src_valid[k]        = 1'b1;
        src_addr[k*AW +: AW] = a;
        src_data[k*DW +: DW] = d;
    endtask

    task automatic clear_src();
        src_valid = '0;
        src_addr  = '0;
        src_data  = '0;
    endtask

    task automatic flush_sb();
        for (int k = 0; k < NS; k++) exp_q[k].delete();
    endtask

    // Record accepts for this edge (model of ready + p0 filter), then advance one cycle.
    task automatic cycle();
        if (!rst)
            for (int k = 0; k < NS; k++)
                if (src_valid[k] && src_ready[k] && src_addr[k*AW +: AW] != '0)
                    exp_q[k].push_back({src_addr[k*AW +: AW], src_data[k*DW +: DW]});
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_src();
        flush_sb();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    function automatic int sb_total();
        int t = 0;
        for (int k = 0; k < NS; k++) t += exp_q[k].size();
        return t;
    endfunction

    initial begin
        // 1: reset with every source valid
        rst = 1'b1;
        for (int k = 0; k < NS; k++) set_src(k, AW'(k + 1), tag(k, 'h100 + k));
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("rst_outputs_valid", {f_vld, s_vld}, '0);
        end
        rst = 1'b0;
        clear_src();
        chk("rst_ready", src_ready, 6'h3F);
        chk("rst_port0", {f_addr, f_data}, '0);
        chk("rst_port1", {s_addr, s_data}, '0);
        cycle();
        chk("rst_no_write", {f_vld, s_vld}, '0);

        // 2: single write latency
        do_reset();
        set_src(0, 6'd5, 64'hDEAD);
        cycle();
        clear_src();
        chk("single_not_early", f_vld, 1'b0);
        cycle();
        chk("single_port0", {f_vld, f_addr, f_data}, {1'b1, 6'd5, 64'hDEAD});
        chk("single_port1_idle", s_vld, 1'b0);

        // 3: all six together -> (1,2),(3,4),(5,6)
        do_reset();
        for (int k = 0; k < NS; k++) set_src(k, AW'(k + 1), tag(k, 'hA000 + k));
        cycle();
        clear_src();
        for (int p = 0; p < 3; p++) begin
            cycle();
            chk("burst_pair_valid", {f_vld, s_vld}, 2'b11);
            chk("burst_pair_addr", {f_addr, s_addr}, {6'(2*p + 1), 6'(2*p + 2)});
        end
        cycle();
        chk("burst_done", {f_vld, s_vld}, 2'b00);
        // rr_ptr is back at 0: the next pair again starts from alu1
        set_src(0, 6'd40, tag(0, 'h40));
        set_src(5, 6'd45, tag(5, 'h45));
        cycle();
        clear_src();
        cycle();
        chk("rr_wrap_order", {f_addr, s_addr}, {6'd40, 6'd45});

        // 4: backpressure on lsu while all sources saturate
        do_reset();
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < NS; k++) set_src(k, AW'(10 + k), tag(k, c));
            cycle();
            if (c == 0) chk("bp_ready_c0", src_ready, 6'h3F);
            if (c == 1) chk("bp_ready_c1", src_ready, 6'b000011);
        end
        clear_src();
        for (int c = 0; c < 24; c++) cycle();
        chk("bp_drained", 70'(sb_total()), '0);

        // 5: same-address conflict and p0 filter
        do_reset();
        set_src(2, 6'd9, tag(2, 'h900F));
        set_src(5, 6'd9, tag(5, 'h9005));
        set_src(1, 6'd0, tag(1, 'hBAD));
        cycle();
        clear_src();
        chk("p0_not_queued_ready", src_ready, 6'h3F);
        cycle();
        chk("conflict_first", {f_vld, f_addr, f_data}, {1'b1, 6'd9, tag(2, 'h900F)});
        chk("conflict_second_idle", s_vld, 1'b0);
        cycle();
        chk("conflict_next", {f_vld, f_addr, f_data}, {1'b1, 6'd9, tag(5, 'h9005)});
        chk("conflict_next_second", s_vld, 1'b0);
        cycle();
        chk("conflict_done", {f_vld, s_vld}, 2'b00);

        // 6: reset while four entries remain queued
        do_reset();
        for (int k = 0; k < NS; k++) set_src(k, AW'(30 + k), tag(k, 'h300 + k));
        cycle();
        clear_src();
        cycle();
        chk("drain_pair", {f_addr, s_addr}, {6'd30, 6'd31});
        rst = 1'b1;
        flush_sb();
        cycle();
        chk("midrst_outputs", {f_vld, s_vld, f_addr, s_addr}, '0);
        rst = 1'b0;
        chk("midrst_ready", src_ready, 6'h3F);
        for (int c = 0; c < 10; c++) cycle();
        chk("sb_empty", 70'(sb_total()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
